sd_delay_arbiter: RTL and testbench
===================================

SD_DELAY_ARBITER -- requirements
Module: sd_delay_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one delay counter.
REQ-002 The block SHALL have parameter COUNT_SIZE, default 4, giving the delay count width in bits.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  NUM_REQ  per-requester delay request, held high until done is seen.
REQ-006 times  input  NUM_REQ*COUNT_SIZE  per-requester delay value; slice i is bits [i*COUNT_SIZE +: COUNT_SIZE].
REQ-007 grant  output  NUM_REQ  one-hot owner of the delay counter; all-zero when idle.
REQ-008 done  output  NUM_REQ  per-requester delay-complete flag.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-011 In IDLE with any req bit high, the block SHALL select one requester round-robin, starting the search at index ptr and wrapping at NUM_REQ.
REQ-012 On that same edge it SHALL register grant as one-hot, latch the winner's times slice, clear count to 0 and enter COUNT.
REQ-013 In COUNT, while count != latched times, the block SHALL increment count by 1 per cycle.
REQ-014 In COUNT, when count == latched times, it SHALL set done[owner] and enter DONE.
REQ-015 Latency SHALL be fixed: with grant registered at edge N, done is registered at edge N+times+1 (times=0 gives done at N+1).
REQ-016 In DONE, grant and done SHALL be held until req[owner] is low.
REQ-017 When req[owner] goes low in DONE, the block SHALL clear grant and done, set ptr to owner+1 (mod NUM_REQ) and enter IDLE.
REQ-018 In COUNT, if req[owner] goes low (abort), the block SHALL clear grant, never assert done, advance ptr as in REQ-017 and enter IDLE.
REQ-019 Changes to the times input or to non-owner req bits after the grant SHALL have no effect on the current delay.
REQ-020 Re-arbitration SHALL occur only in IDLE, so there is at least one idle cycle between consecutive grants.
REQ-021 count SHALL be COUNT_SIZE bits wide; it never exceeds latched times, so no wrap occurs (max times = 2^COUNT_SIZE-1).
REQ-022 At most one grant bit and at most one done bit SHALL be high in any cycle, and done[i] SHALL imply grant[i].
REQ-023 An unused state encoding SHALL return to IDLE on the next edge with all outputs cleared.

Reset
REQ-024 While rst_n is low: grant=0, done=0, busy=0, count=0, ptr=0, state=IDLE, applied immediately without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL abandon the delay in progress; after release, arbitration restarts from requester 0.

Structure
REQ-026 Shared package sd_pkg SHALL hold the state encoding (IDLE/COUNT/DONE) and the default COUNT_SIZE.
REQ-027 The counter and compare logic (load, enable, count==times match flag) SHALL be the sub-module sd_delay_counter; the arbiter/FSM is the top.

Verification
REQ-028 req=0001, times[0]=3 -> grant=0001 one cycle later; done[0] rises 4 edges after grant; hold req 2 extra cycles -> done stays high; drop req -> grant=0, done=0 next edge.
REQ-029 times[2]=0, req=0100 -> done[2] asserts on the edge after grant.
REQ-030 req=1111 held and each requester released on done -> grants in order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
REQ-031 Abort: req=0010, times[1]=10, drop req after 3 count cycles -> grant clears next edge, done[1] never asserts, next grant goes to index 2 if requested.
REQ-032 times[0] changed from 5 to 1 during COUNT -> done still arrives at grant+6.
REQ-033 rst_n pulsed low mid-COUNT -> outputs zero asynchronously; after release with req=1001 -> grant=0001.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the delay arbiter: FSM encoding, default sizes and
// the round-robin pointer advance helper.
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sd_state_t;

    localparam int SD_NUM_REQ    = 4;
    localparam int SD_COUNT_SIZE = 4;

    // Index following idx in a ring of n requesters.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sd_delay_arbiter_if.sv
// Request/grant bundle between requesters (master) and the delay arbiter (slave).
interface sd_delay_arbiter_if
    import sd_pkg::*;
#(
    parameter int NUM_REQ    = SD_NUM_REQ,
    parameter int COUNT_SIZE = SD_COUNT_SIZE
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*COUNT_SIZE-1:0] times;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          busy;

    modport master (output req, times, input grant, done, busy);
    modport slave  (input req, times, output grant, done, busy);

endinterface

// File: rtl/sd_delay_counter.sv
// Shared delay counter: load latches the limit and zeroes the count, enable
// steps it, match flags count == latched limit.
module sd_delay_counter
    import sd_pkg::*;
#(
    parameter int COUNT_SIZE = SD_COUNT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  enable,
    input  logic [COUNT_SIZE-1:0] load_value,
    output logic                  match
);

    logic [COUNT_SIZE-1:0] count_reg;
    logic [COUNT_SIZE-1:0] limit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            limit_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
            limit_reg <= load_value;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Count stops at the limit, so it can never wrap.
    assign match = (count_reg == limit_reg);

endmodule

// File: rtl/sd_delay_arbiter.sv
// Round-robin arbiter sharing one delay counter among NUM_REQ requesters;
// the owner holds grant/done until it drops its request.
module sd_delay_arbiter
    import sd_pkg::*;
#(
    parameter int NUM_REQ    = SD_NUM_REQ,
    parameter int COUNT_SIZE = SD_COUNT_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    sd_delay_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sd_state_t          state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] done_reg,  done_next;
    logic [PTR_W-1:0]   ptr_reg,   ptr_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;

    logic [COUNT_SIZE-1:0] times_arr [NUM_REQ];
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      owner_adv;
    logic                  found;
    int                    idx;
    logic                  cnt_load;
    logic                  cnt_en;
    logic                  cnt_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_times
            assign times_arr[gi] = bus.times[gi*COUNT_SIZE +: COUNT_SIZE];
        end
    endgenerate

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_reg) + k) % NUM_REQ;
            if (!found && bus.req[PTR_W'(idx)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    assign owner_adv = PTR_W'(next_index(int'(owner_reg), NUM_REQ));

    sd_delay_counter #(.COUNT_SIZE(COUNT_SIZE)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .enable     (cnt_en),
        .load_value (times_arr[win_idx]),
        .match      (cnt_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            done_reg  <= '0;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        done_next  = done_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_next = '0;
                done_next  = '0;
                if (found) begin
                    owner_next          = win_idx;
                    grant_next[win_idx] = 1'b1;
                    cnt_load            = 1'b1;
                    state_next          = COUNT;
                end
            end
            COUNT: begin
                // A dropped request aborts before the match is considered.
                if (!bus.req[owner_reg]) begin
                    grant_next = '0;
                    ptr_next   = owner_adv;
                    state_next = IDLE;
                end else if (cnt_match) begin
                    done_next[owner_reg] = 1'b1;
                    state_next           = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                if (!bus.req[owner_reg]) begin
                    grant_next = '0;
                    done_next  = '0;
                    ptr_next   = owner_adv;
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                done_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign bus.grant = grant_reg;
    assign bus.done  = done_reg;
    assign bus.busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_sd_delay_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/done changes with their
// edge spacing; a monitor compares every observed change against the queue.
module tb_sd_delay_arbiter;

    localparam int NR = 4;
    localparam int CS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_delay_arbiter_if #(.NUM_REQ(NR), .COUNT_SIZE(CS)) bus ();

    sd_delay_arbiter #(.NUM_REQ(NR), .COUNT_SIZE(CS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NR-1:0] g;
        logic [NR-1:0] d;
        int            dl;   // edges since previous change, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_evt = 0;
    logic [NR-1:0] prev_g = '0;
    logic [NR-1:0] prev_d = '0;

    function automatic void expect_evt(input logic [NR-1:0] g, input logic [NR-1:0] d, input int dl);
        exp_t e;
        e.g  = g;
        e.d  = d;
        e.dl = dl;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("check %s ok value=%0h", name, got);
        end
    endfunction

    // Monitor: one comparison per observed grant/done change.
    always @(posedge clk) begin
        exp_t e;
        int   dl;
        cyc++;
        #1;
        if (bus.grant !== prev_g || bus.done !== prev_d) begin
            dl       = cyc - last_evt;
            last_evt = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got grant=%b done=%b want none (cycle %0d)",
                         bus.grant, bus.done, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant !== e.g || bus.done !== e.d || (e.dl >= 0 && dl != e.dl)) begin
                    bad++;
                    $display("FAIL event got grant=%b done=%b delta=%0d want grant=%b done=%b delta=%0d",
                             bus.grant, bus.done, dl, e.g, e.d, e.dl);
                end else begin
                    $display("event grant=%b done=%b delta=%0d ok", bus.grant, bus.done, dl);
                end
            end
            total++;
            if ($countones(bus.grant) > 1 || $countones(bus.done) > 1 || (bus.done & ~bus.grant) != '0) begin
                bad++;
                $display("FAIL onehot got grant=%b done=%b want one-hot with done within grant",
                         bus.grant, bus.done);
            end
            prev_g = bus.grant;
            prev_d = bus.done;
        end
    end

    task automatic wait_for(input string name, input logic [NR-1:0] mask, input bit on_done);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (on_done ? ((bus.done & mask) != '0) : ((bus.grant & mask) != '0)) break;
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL timeout_%s got no event in 60 cycles want mask=%b", name, mask);
                break;
            end
        end
    endtask

    initial begin
        logic [NR-1:0] m;
        bus.req   = '0;
        bus.times = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_grant", 32'(bus.grant), 32'h0);
        chk("reset_done",  32'(bus.done),  32'h0);
        chk("reset_busy",  32'(bus.busy),  32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin with all requesters, each times = 1
        bus.times = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            m = NR'(1) << (k % NR);
            expect_evt(m, '0, (k == 0) ? -1 : 1);
            expect_evt(m, m, 2);
            expect_evt('0, '0, 1);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            m = NR'(1) << (k % NR);
            wait_for("rr_done", m, 1'b1);
            if (k < 4) begin
                bus.req = bus.req & ~m;
                @(negedge clk);
                bus.req = bus.req | m;
            end else begin
                bus.req = '0;
            end
        end
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'h0);

        // times[0]=3, done held while req stays high
        bus.times = 16'h0003;
        expect_evt(4'b0001, 4'b0000, -1);
        expect_evt(4'b0001, 4'b0001, 4);
        expect_evt(4'b0000, 4'b0000, 3);
        bus.req = 4'b0001;
        wait_for("t3_grant", 4'b0001, 1'b0);
        chk("t3_busy", 32'(bus.busy), 32'h1);
        wait_for("t3_done", 4'b0001, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("t3_done_held", 32'(bus.done), 32'h1);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);

        // times[2]=0: done on the edge after grant
        bus.times = 16'h0000;
        expect_evt(4'b0100, 4'b0000, -1);
        expect_evt(4'b0100, 4'b0100, 1);
        expect_evt(4'b0000, 4'b0000, 1);
        bus.req = 4'b0100;
        wait_for("t0_done", 4'b0100, 1'b1);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Abort requester 1 after 3 count cycles; next grant goes to 2
        bus.times = 16'h00A0;
        expect_evt(4'b0010, 4'b0000, -1);
        expect_evt(4'b0000, 4'b0000, 4);
        expect_evt(4'b0100, 4'b0000, 1);
        expect_evt(4'b0100, 4'b0100, 1);
        expect_evt(4'b0000, 4'b0000, 1);
        bus.req = 4'b0010;
        wait_for("abort_grant", 4'b0010, 1'b0);
        repeat (3) @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        chk("abort_grant_clear", 32'(bus.grant), 32'h0);
        chk("abort_no_done", 32'(bus.done), 32'h0);
        bus.req = 4'b0101;
        wait_for("abort_next_done", 4'b0100, 1'b1);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // times[0] changed 5 -> 1 mid-count: done still at grant+6
        bus.times = 16'h0005;
        expect_evt(4'b0001, 4'b0000, -1);
        expect_evt(4'b0001, 4'b0001, 6);
        expect_evt(4'b0000, 4'b0000, 1);
        bus.req = 4'b0001;
        wait_for("chg_grant", 4'b0001, 1'b0);
        bus.times = 16'h0001;
        wait_for("chg_done", 4'b0001, 1'b1);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-count, then restart from requester 0
        bus.times = 16'h9009;
        expect_evt(4'b1000, 4'b0000, -1);
        expect_evt(4'b0000, 4'b0000, -1);
        expect_evt(4'b0001, 4'b0000, 1);
        expect_evt(4'b0001, 4'b0001, 10);
        expect_evt(4'b0000, 4'b0000, 1);
        bus.req = 4'b1000;
        wait_for("rst_grant", 4'b1000, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(bus.grant), 32'h0);
        chk("async_rst_done",  32'(bus.done),  32'h0);
        chk("async_rst_busy",  32'(bus.busy),  32'h0);
        bus.req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        wait_for("rst_done", 4'b0001, 1'b1);
        bus.req = '0;
        repeat (5) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
